// File: rtl/ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// ram_arb_pkg
// Shared constants for the RAM port arbiter slice:
//   - default RAM address/data widths
//   - FSM state encodings (RUN / DRAIN / HALT)
//   - grant encoding used by the round-robin last_grant register
// No ports; imported by rr_arb2 and ram_port_arbiter.
// -----------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. Requester 0 is the write side, requester
// 1 the read side. When both request, the one that did not win last time is
// granted. The last_grant register only moves when a grant is actually taken.
// Ports:
//   clk        in   clock
//   kill_n     in   asynchronous active-low reset (last_grant -> GNT_RD)
//   req_i      in   [1:0] request vector {rd, wr}
//   enable_i   in   1 = grants allowed this cycle
//   accept_i   in   1 = the current grant is taken this cycle
//   gnt_o      out  [1:0] one-hot (or zero) combinational grant {rd, wr}
// -----------------------------------------------------------------------------
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       kill_n,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic [1:0] gnt_s;
    logic       last_grant_q;
    logic       last_grant_d;

    // Grant selection: single requester wins outright, a tie goes to the side
    // that was not granted last.
    always_comb begin
        gnt_s = 2'b00;
        if (enable_i) begin
            case (req_i)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (last_grant_q == GNT_RD) ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Next value of the round-robin pointer, moved only by a taken grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_i) begin
            last_grant_d = gnt_s[1] ? GNT_RD : GNT_WR;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin pointer register; reset to RD so the write side wins the
    // first tie.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            last_grant_q <= GNT_RD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM between a write requester and a read requester.
// One access per clock, round-robin arbitration, registered RAM command
// outputs, and read data returned RD_LATENCY+2 cycles after acceptance with a
// one-cycle rd_valid strobe. The hold input stops new grants, lets in-flight
// reads drain, and then parks the block in HALT until hold drops.
//
// Optional feature: define RAM_ARB_STATS_EN to add 16-bit wrapping counters
// of accepted writes (wr_count) and reads (rd_count).
//
// Ports:
//   clk          in   system clock, posedge
//   kill_n       in   asynchronous active-low reset
//   hold         in   1 = stop granting, drain in-flight reads
//   wr_req       in   write request
//   wr_addr      in   [ADDR_W] write address
//   wr_data      in   [DATA_W] write data
//   wr_ready     out  combinational write grant
//   rd_req       in   read request
//   rd_addr      in   [ADDR_W] read address
//   rd_ready     out  combinational read grant
//   rd_valid     out  one-cycle pulse, rd_data valid
//   rd_data      out  [DATA_W] registered read result
//   halted       out  1 = HALT state, nothing in flight
//   ram_address  out  [ADDR_W] registered RAM address
//   ram_data     out  [DATA_W] registered RAM write data
//   ram_wren     out  registered RAM write enable
//   ram_rden     out  registered RAM read enable
//   ram_q        in   [DATA_W] RAM read data
//   wr_count     out  [16] accepted writes (RAM_ARB_STATS_EN only)
//   rd_count     out  [16] accepted reads  (RAM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              kill_n,
    input  logic              hold,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              halted,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  enable_s;
    logic [1:0]            gnt_s;
    logic                  accept_s;
    logic                  pipe_busy_s;

    logic [ADDR_W-1:0]     ram_address_q;
    logic [ADDR_W-1:0]     ram_address_d;
    logic [DATA_W-1:0]     ram_data_q;
    logic [DATA_W-1:0]     ram_data_d;
    logic                  ram_wren_q;
    logic                  ram_rden_q;

    logic [RD_LATENCY-1:0] tag_q;
    logic [RD_LATENCY-1:0] tag_d;
    logic                  rd_valid_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic [DATA_W-1:0]     rd_data_d;
    logic                  halted_q;

    // Grants only in RUN with hold low. kill_n is folded in so the
    // combinational readies are also 0 while reset is asserted.
    assign enable_s = kill_n & (state_q == RUN) & ~hold;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .kill_n   (kill_n),
        .req_i    ({rd_req, wr_req}),
        .enable_i (enable_s),
        .accept_i (accept_s),
        .gnt_o    (gnt_s)
    );

    // A grant is only issued to an active requester, so any grant is a
    // completed handshake.
    assign accept_s = |gnt_s;
    assign wr_ready = gnt_s[0];
    assign rd_ready = gnt_s[1];

    // Reads still travelling: the rden being presented to the RAM now plus
    // every tag in the latency pipeline.
    assign pipe_busy_s = ram_rden_q | (|tag_q);

    // FSM next state: RUN -> DRAIN on hold, DRAIN -> HALT once empty,
    // back to RUN whenever hold drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (hold) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!hold) begin
                    state_d = RUN;
                end else if (!pipe_busy_s) begin
                    state_d = HALT;
                end else begin
                    state_d = DRAIN;
                end
            end
            HALT: begin
                if (hold) begin
                    state_d = HALT;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Command-stage next values: address follows the winner, write data only
    // changes on a write; both hold when nothing is granted.
    always_comb begin
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        if (gnt_s[0]) begin
            ram_address_d = wr_addr;
            ram_data_d    = wr_data;
        end else if (gnt_s[1]) begin
            ram_address_d = rd_addr;
            ram_data_d    = ram_data_q;
        end else begin
            ram_address_d = ram_address_q;
            ram_data_d    = ram_data_q;
        end
    end

    // Read tag shift register; stage 0 is loaded from the rden being driven
    // to the RAM this cycle.
    always_comb begin
        tag_d    = {RD_LATENCY{1'b0}};
        tag_d[0] = ram_rden_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Capture ram_q when the oldest tag leaves the pipeline.
    always_comb begin
        rd_data_d = rd_data_q;
        if (tag_q[RD_LATENCY-1]) begin
            rd_data_d = ram_q;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // FSM state and halted flag registers.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
        end
    end

    // Registered RAM command stage; enables are single-cycle because the
    // grant vector is one-hot and recomputed every cycle.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            ram_address_q <= {ADDR_W{1'b0}};
            ram_data_q    <= {DATA_W{1'b0}};
            ram_wren_q    <= 1'b0;
            ram_rden_q    <= 1'b0;
        end else begin
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= gnt_s[0];
            ram_rden_q    <= gnt_s[1];
        end
    end

    // Read tag pipeline and read-return registers; reset discards every
    // in-flight read.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            tag_q      <= {RD_LATENCY{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
        end else begin
            tag_q      <= tag_d;
            rd_valid_q <= tag_q[RD_LATENCY-1];
            rd_data_q  <= rd_data_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign ram_rden    = ram_rden_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign halted      = halted_q;

`ifdef RAM_ARB_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] wr_cnt_d;
    logic [15:0] rd_cnt_q;
    logic [15:0] rd_cnt_d;

    // Accepted-transfer counters; natural 16-bit wrap from FFFF to 0.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (gnt_s[0]) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        if (gnt_s[1]) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM
// (RD_LATENCY-stage read pipeline). Inputs change 1 time unit after posedge,
// outputs are sampled on the following negedge.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          kill_n;
    logic          hold;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          halted;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic          ram_rden;
    logic [DW-1:0] ram_q;
`ifdef RAM_ARB_STATS_EN
    logic [15:0]   wr_count;
    logic [15:0]   rd_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clk         (clk),
        .kill_n      (kill_n),
        .hold        (hold),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .halted      (halted),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
`ifdef RAM_ARB_STATS_EN
        ,
        .wr_count    (wr_count),
        .rd_count    (rd_count)
`endif
    );

    // Behavioural single-port RAM: q is valid LAT cycles after rden.
    logic [DW-1:0] mem   [256];
    logic [DW-1:0] qpipe [LAT];

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        if (ram_rden) qpipe[0] <= mem[ram_address];
        for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
    end
    assign ram_q = qpipe[LAT-1];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {10'd0, ram_wren, ram_rden, rd_valid, halted, wr_ready, rd_ready}, 16'h0000);
        chk({tag, "_addr"}, {8'd0, ram_address}, 16'h0000);
        chk({tag, "_data"}, {8'd0, ram_data}, 16'h0000);
        chk({tag, "_rdat"}, {8'd0, rd_data}, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < LAT; i++) qpipe[i] = 8'h00;
        kill_n = 1'b0; hold = 1'b0;
        wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        rd_req = 1'b0; rd_addr = 8'h00;

        // Reset state
        repeat (2) nxt();
        smp();
        chk_all_zero("reset");
        nxt();
        kill_n = 1'b1;
        smp();
        chk("post_reset_halted", {15'd0, halted}, 16'h0000);

        // Single write: addr 05, data 0A
        nxt();
        wr_req = 1'b1; wr_addr = 8'h05; wr_data = 8'h0A;
        smp();
        chk("wr1_ready", {14'd0, wr_ready, rd_ready}, 16'h0002);
        nxt();
        wr_req = 1'b0;
        smp();
        chk("wr1_cmd", {14'd0, ram_wren, ram_rden}, 16'h0002);
        chk("wr1_addr", {8'd0, ram_address}, 16'h0005);
        chk("wr1_data", {8'd0, ram_data}, 16'h000A);
        nxt();
        smp();
        chk("wr1_pulse_end", {14'd0, ram_wren, ram_rden}, 16'h0000);
        chk("wr1_addr_hold", {8'd0, ram_address}, 16'h0005);

        // Write 3C to 10, then read 10 back (latency LAT+2 from accept)
        nxt();
        wr_req = 1'b1; wr_addr = 8'h10; wr_data = 8'h3C;
        smp();
        chk("wr2_ready", {15'd0, wr_ready}, 16'h0001);
        nxt();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h10;
        smp();
        chk("rd2_ready", {14'd0, wr_ready, rd_ready}, 16'h0001);
        nxt();
        rd_req = 1'b0;
        smp();
        chk("rd2_cmd", {14'd0, ram_wren, ram_rden}, 16'h0001);
        chk("rd2_addr", {8'd0, ram_address}, 16'h0010);
        chk("rd2_valid_n1", {15'd0, rd_valid}, 16'h0000);
        nxt(); smp();
        chk("rd2_valid_n2", {15'd0, rd_valid}, 16'h0000);
        nxt(); smp();
        chk("rd2_valid_n3", {15'd0, rd_valid}, 16'h0000);
        nxt(); smp();
        chk("rd2_valid_n4", {15'd0, rd_valid}, 16'h0001);
        chk("rd2_data", {8'd0, rd_data}, 16'h003C);
        nxt(); smp();
        chk("rd2_valid_n5", {15'd0, rd_valid}, 16'h0000);

        // Contention from reset: grants W,R,W,R
        nxt();
        kill_n = 1'b0;
        nxt();
        kill_n = 1'b1;
        wr_req = 1'b1; wr_addr = 8'h20; wr_data = 8'h55;
        rd_req = 1'b1; rd_addr = 8'h30;
        smp();
        chk("cont_c0_gnt", {14'd0, wr_ready, rd_ready}, 16'h0002);
        nxt(); smp();
        chk("cont_c1_gnt", {14'd0, wr_ready, rd_ready}, 16'h0001);
        chk("cont_c1_cmd", {14'd0, ram_wren, ram_rden}, 16'h0002);
        nxt(); smp();
        chk("cont_c2_gnt", {14'd0, wr_ready, rd_ready}, 16'h0002);
        chk("cont_c2_cmd", {14'd0, ram_wren, ram_rden}, 16'h0001);
        nxt(); smp();
        chk("cont_c3_gnt", {14'd0, wr_ready, rd_ready}, 16'h0001);
        chk("cont_c3_cmd", {14'd0, ram_wren, ram_rden}, 16'h0002);
        nxt();
        wr_req = 1'b0; rd_req = 1'b0;
        smp();
        chk("cont_c4_cmd", {14'd0, ram_wren, ram_rden}, 16'h0001);
        repeat (6) nxt();

        // Hold with two reads in flight
        rd_req = 1'b1; rd_addr = 8'h05;
        smp();
        chk("hold_h0_rdy", {15'd0, rd_ready}, 16'h0001);
        nxt();
        rd_addr = 8'h10;
        smp();
        chk("hold_h1_rdy", {15'd0, rd_ready}, 16'h0001);
        nxt();
        hold = 1'b1; wr_req = 1'b1; wr_addr = 8'h40; wr_data = 8'h77;
        smp();
        chk("hold_h2_rdy", {14'd0, wr_ready, rd_ready}, 16'h0000);
        chk("hold_h2_halt", {15'd0, halted}, 16'h0000);
        nxt(); smp();
        chk("hold_h3_rdy", {14'd0, wr_ready, rd_ready}, 16'h0000);
        chk("hold_h3_vh", {14'd0, rd_valid, halted}, 16'h0000);
        nxt(); smp();
        chk("hold_h4_vh", {14'd0, rd_valid, halted}, 16'h0002);
        chk("hold_h4_data", {8'd0, rd_data}, 16'h000A);
        nxt(); smp();
        chk("hold_h5_vh", {14'd0, rd_valid, halted}, 16'h0002);
        chk("hold_h5_data", {8'd0, rd_data}, 16'h003C);
        chk("hold_h5_rdy", {14'd0, wr_ready, rd_ready}, 16'h0000);
        nxt(); smp();
        chk("hold_h6_vh", {14'd0, rd_valid, halted}, 16'h0001);
        chk("hold_h6_rdy", {14'd0, wr_ready, rd_ready}, 16'h0000);
        nxt();
        hold = 1'b0;
        smp();
        chk("rel_h7_rdy", {14'd0, wr_ready, rd_ready}, 16'h0000);
        chk("rel_h7_halt", {15'd0, halted}, 16'h0001);
        nxt(); smp();
        chk("rel_h8_rdy", {14'd0, wr_ready, rd_ready}, 16'h0002);
        chk("rel_h8_halt", {15'd0, halted}, 16'h0000);
        nxt();
        wr_req = 1'b0;
        smp();
        chk("rel_h9_rdy", {14'd0, wr_ready, rd_ready}, 16'h0001);
        nxt();
        rd_req = 1'b0;
        repeat (6) nxt();

        // Reset one cycle after a read accept
        rd_req = 1'b1; rd_addr = 8'h40;
        smp();
        chk("kill_acc_rdy", {15'd0, rd_ready}, 16'h0001);
        nxt();
        rd_req = 1'b0; kill_n = 1'b0;
        smp();
        chk_all_zero("kill_mid");
        nxt();
        kill_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("kill_no_valid", {15'd0, rd_valid}, 16'h0000);
            nxt();
        end

`ifdef RAM_ARB_STATS_EN
        // Counters: 3 writes then 5 reads, then wrap from FFFF
        wr_req = 1'b1; wr_addr = 8'h50; wr_data = 8'h11;
        repeat (3) nxt();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h50;
        repeat (5) nxt();
        rd_req = 1'b0;
        smp();
        chk("stats_wr", wr_count, 16'd3);
        chk("stats_rd", rd_count, 16'd5);
        nxt();
        force dut.wr_cnt_q = 16'hFFFF;
        #1;
        release dut.wr_cnt_q;
        wr_req = 1'b1;
        nxt();
        wr_req = 1'b0;
        smp();
        chk("stats_wrap", wr_count, 16'd0);
        repeat (6) nxt();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
